// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//
// Control-path sequencer for one DSP slice used as a multiply-accumulator.
// A job (term count, subtract flag) is accepted from the scheduler. Operand
// beats are then paced through a valid/ready handshake. Each accepted beat
// produces one registered INMODE/OPMODE/ALUMODE control word one cycle later.
// done pulses once the accumulated result is stable at P.
//
// Build option:
//   DSP_MAC_PREADD_EN - adds the preadd input. When it is latched high, the
//                       issued words select the D+A pre-adder (INMODE 00100).
//
// Ports:
//   clk        system clock, rising edge
//   RST        synchronous active-high reset
//   start      job request, sampled only in IDLE
//   len        number of product terms (0 = request ignored)
//   sub        1 = accumulate P - M, sampled with start
//   preadd     (DSP_MAC_PREADD_EN only) pre-adder select, sampled with start
//   in_valid   operand beat present at the slice inputs
//   in_ready   sequencer takes a beat this cycle
//   busy       job in progress
//   done       one-cycle pulse, result valid at P
//   op_valid   control word below is live this cycle
//   INMODE_o   INMODE to the slice
//   OPMODE_o   OPMODE to the slice
//   ALUMODE_o  ALUMODE to the slice
//   CEINMODE   INMODE register clock enable (mirrors op_valid)
//   CEP        P register clock enable
//   RSTP       P register reset pulse at job start
//
// state | meaning
// IDLE  | waiting for start with a non-zero len
// FIRST | waiting for the first beat; its word loads P with M (Z=0)
// ACCUM | remaining beats; each word accumulates onto P (Z=P)
// DRAIN | last word live, then PIPE_LAT cycles for it to reach P
// DONE  | result stable at P, done pulse

module dsp_mac_sequencer #(
   parameter int LEN_W    = 8,
   parameter int PIPE_LAT = 3
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             sub,
`ifdef DSP_MAC_PREADD_EN
   input  logic             preadd,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             op_valid,
   output logic [4:0]       INMODE_o,
   output logic [6:0]       OPMODE_o,
   output logic [3:0]       ALUMODE_o,
   output logic             CEINMODE,
   output logic             CEP,
   output logic             RSTP
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FIRST = 3'd1,
      ACCUM = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [LEN_W-1:0] CNT_ONE    = LEN_W'(1);
   localparam logic [3:0]       DRAIN_LOAD = 4'(PIPE_LAT);
   localparam logic [6:0]       OPM_FIRST  = 7'b000_01_01;
   localparam logic [6:0]       OPM_ACCUM  = 7'b010_01_01;
   localparam logic [3:0]       ALU_ADD    = 4'b0000;
   localparam logic [3:0]       ALU_SUB    = 4'b0011;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [3:0]       drain_q, drain_d;
   logic             sub_q, sub_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             op_valid_q, op_valid_d;
   logic [4:0]       inmode_q, inmode_d;
   logic [6:0]       opmode_q, opmode_d;
   logic [3:0]       alumode_q, alumode_d;
   logic             cep_q, cep_d;
   logic             rstp_q, rstp_d;
   logic             accept;
   logic [4:0]       inmode_word;

`ifdef DSP_MAC_PREADD_EN
   logic pre_q, pre_d;
   assign inmode_word = pre_q ? 5'b00100 : 5'b00000;
`else
   assign inmode_word = 5'b00000;
`endif

   assign accept = in_valid & in_ready_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drain_d    = drain_q;
      sub_d      = sub_q;
`ifdef DSP_MAC_PREADD_EN
      pre_d      = pre_q;
`endif
      op_valid_d = 1'b0;
      inmode_d   = 5'b00000;
      opmode_d   = 7'b0000000;
      alumode_d  = 4'b0000;
      rstp_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && (len != '0)) begin
               cnt_d   = len;
               sub_d   = sub;
`ifdef DSP_MAC_PREADD_EN
               pre_d   = preadd;
`endif
               rstp_d  = 1'b1;
               state_d = FIRST;
            end
         end
         FIRST, ACCUM: begin
            if (accept) begin
               op_valid_d = 1'b1;
               inmode_d   = inmode_word;
               cnt_d      = cnt_q - CNT_ONE;
               if (state_q == FIRST) begin
                  opmode_d  = OPM_FIRST;
                  alumode_d = ALU_ADD;
               end else begin
                  opmode_d  = OPM_ACCUM;
                  alumode_d = sub_q ? ALU_SUB : ALU_ADD;
               end
               if (cnt_q > CNT_ONE) begin
                  state_d = ACCUM;
               end else begin
                  // The final word is live in the first DRAIN cycle. PIPE_LAT
                  // more cycles follow before P holds the finished sum.
                  state_d = DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end
         end
         DRAIN: begin
            if (drain_q == 4'd0) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == FIRST) || (state_d == ACCUM);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      // ACCUM and DRAIN are only entered on an accepted beat, so this spans
      // the first issued word through the last drain cycle.
      cep_d      = (state_d == ACCUM) || (state_d == DRAIN);
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         drain_q    <= 4'd0;
         sub_q      <= 1'b0;
`ifdef DSP_MAC_PREADD_EN
         pre_q      <= 1'b0;
`endif
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         op_valid_q <= 1'b0;
         inmode_q   <= 5'b00000;
         opmode_q   <= 7'b0000000;
         alumode_q  <= 4'b0000;
         cep_q      <= 1'b0;
         rstp_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         drain_q    <= drain_d;
         sub_q      <= sub_d;
`ifdef DSP_MAC_PREADD_EN
         pre_q      <= pre_d;
`endif
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         op_valid_q <= op_valid_d;
         inmode_q   <= inmode_d;
         opmode_q   <= opmode_d;
         alumode_q  <= alumode_d;
         cep_q      <= cep_d;
         rstp_q     <= rstp_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign op_valid  = op_valid_q;
   assign INMODE_o  = inmode_q;
   assign OPMODE_o  = opmode_q;
   assign ALUMODE_o = alumode_q;
   assign CEINMODE  = op_valid_q;
   assign CEP       = cep_q;
   assign RSTP      = rstp_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer. Expected control words are
// queued as beats are offered to the DUT. A negedge monitor pops and compares
// them whenever op_valid is seen. Build with +define+DSP_MAC_PREADD_EN to
// exercise the pre-adder option.

module tb_dsp_mac_sequencer;

   localparam int LEN_W    = 8;
   localparam int PIPE_LAT = 3;

   logic             clk      = 1'b0;
   logic             RST      = 1'b1;
   logic             start    = 1'b0;
   logic [LEN_W-1:0] len      = '0;
   logic             sub      = 1'b0;
   logic             preadd   = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready, busy, done, op_valid, CEINMODE, CEP, RSTP;
   logic [4:0]       INMODE_o;
   logic [6:0]       OPMODE_o;
   logic [3:0]       ALUMODE_o;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_w;

   always #5 clk = ~clk;

   dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
      .clk       (clk),
      .RST       (RST),
      .start     (start),
      .len       (len),
      .sub       (sub),
`ifdef DSP_MAC_PREADD_EN
      .preadd    (preadd),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .busy      (busy),
      .done      (done),
      .op_valid  (op_valid),
      .INMODE_o  (INMODE_o),
      .OPMODE_o  (OPMODE_o),
      .ALUMODE_o (ALUMODE_o),
      .CEINMODE  (CEINMODE),
      .CEP       (CEP),
      .RSTP      (RSTP)
   );

   function automatic logic [4:0] exp_inmode(input logic p);
`ifdef DSP_MAC_PREADD_EN
      return p ? 5'b00100 : 5'b00000;
`else
      return (p & 1'b0) ? 5'b11111 : 5'b00000;
`endif
   endfunction

   // Word monitor: every op_valid cycle must match the oldest queued word;
   // every other cycle must carry an all-zero control word.
   always @(negedge clk) begin
      if (op_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL word_extra got in=%h op=%h alu=%h required no word",
                     INMODE_o, OPMODE_o, ALUMODE_o);
         end else begin
            mon_w = exp_q.pop_front();
            if ({INMODE_o, OPMODE_o, ALUMODE_o} !== mon_w) begin
               errors++;
               $display("FAIL word got in=%h op=%h alu=%h required in=%h op=%h alu=%h",
                        INMODE_o, OPMODE_o, ALUMODE_o, mon_w[15:11], mon_w[10:4], mon_w[3:0]);
            end
         end
         checks++;
         if ({CEINMODE, CEP} !== 2'b11) begin
            errors++;
            $display("FAIL strobes_issue got ceinmode=%b cep=%b required 1 1", CEINMODE, CEP);
         end
      end else begin
         checks++;
         if ({INMODE_o, OPMODE_o, ALUMODE_o, CEINMODE} !== 17'd0) begin
            errors++;
            $display("FAIL idle_word got op_valid=%b in=%h op=%h alu=%h ce=%b required zero",
                     op_valid, INMODE_o, OPMODE_o, ALUMODE_o, CEINMODE);
         end
      end
   end

   // Runs one job from the current cycle (#1 after an edge, DUT idle).
   // pat gives in_valid per offered cycle; past patlen in_valid is held 1.
   task automatic run_job(input logic [7:0] n, input logic s, input logic p,
                          input logic [15:0] pat, input int patlen,
                          input bit bstart, input bit dstart, input string nm);
      int   remaining;
      int   idx;
      bit   first;
      logic v;
      start = 1'b1; len = n; sub = s; preadd = p;
      @(posedge clk); #1;
      start = 1'b0; len = 8'($urandom); sub = ~s; preadd = ~p;
      checks++;
      if ({busy, RSTP} !== 2'b11) begin
         errors++;
         $display("FAIL %s_start got busy=%b rstp=%b required 1 1", nm, busy, RSTP);
      end
      remaining = n; idx = 0; first = 1'b1;
      while (remaining > 0) begin
         if (idx > 64) begin
            errors++;
            $display("FAIL %s_timeout got %0d beats left required 0", nm, remaining);
            break;
         end
         v        = (idx < patlen) ? pat[idx] : 1'b1;
         start    = bstart && (idx == 1);
         if (start) len = 8'd9;
         in_valid = v;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got %b required 1 (beat offer %0d)", nm, in_ready, idx);
         end
         if (v) begin
            exp_q.push_back({exp_inmode(p), first ? 7'h05 : 7'h25,
                             (first || !s) ? 4'h0 : 4'h3});
            remaining--;
            first = 1'b0;
         end
         idx++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; start = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_ready_after got %b required 0", nm, in_ready);
      end
      // Last word live now; done is due PIPE_LAT+1 cycles later.
      for (int i = 0; i <= PIPE_LAT; i++) begin
         checks++;
         if ({done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL %s_drain got done=%b busy=%b required 0 1 (cycle %0d)", nm, done, busy, i);
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({done, busy, CEP} !== 3'b110) begin
         errors++;
         $display("FAIL %s_done got done=%b busy=%b cep=%b required 1 1 0", nm, done, busy, CEP);
      end
      if (dstart) begin
         start = 1'b1; len = 8'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL %s_idle got done=%b busy=%b required 0 0", nm, done, busy);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_words got %0d pending required 0", nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge clk);
      #1 RST = 1'b0;
      checks++;
      if ({in_ready, busy, done, op_valid, CEINMODE, CEP, RSTP, INMODE_o, OPMODE_o, ALUMODE_o} !== 23'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b required all 0",
                  {in_ready, busy, done, op_valid, CEINMODE, CEP, RSTP, INMODE_o, OPMODE_o, ALUMODE_o});
      end
   endtask

   task automatic test_single();
      run_job(8'd1, 1'b0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0, "single");
   endtask

   task automatic test_stall();
      run_job(8'd4, 1'b0, 1'b0, 16'h0059, 7, 1'b0, 1'b0, "stall");
   endtask

   task automatic test_subtract();
      run_job(8'd3, 1'b1, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0, "subtract");
   endtask

   task automatic test_ignored_starts();
      start = 1'b1; len = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({busy, in_ready, RSTP} !== 3'b000) begin
            errors++;
            $display("FAIL len0_start got busy=%b ready=%b rstp=%b required 0 0 0", busy, in_ready, RSTP);
         end
         @(posedge clk); #1;
      end
      run_job(8'd4, 1'b0, 1'b0, 16'h0005, 4, 1'b1, 1'b1, "busy_start");
   endtask

   task automatic test_preadd();
      run_job(8'd2, 1'b0, 1'b1, 16'hFFFF, 0, 1'b0, 1'b0, "preadd1");
      run_job(8'd2, 1'b1, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0, "preadd0");
   endtask

   task automatic test_back_to_back();
      run_job(8'd2, 1'b1, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0, "b2b_a");
      run_job(8'd5, 1'b1, 1'b1, 16'h0015, 6, 1'b0, 1'b0, "b2b_b");
   endtask

   task automatic test_reset_mid_job();
      start = 1'b1; len = 8'd5; sub = 1'b0; preadd = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      exp_q.push_back({5'b00000, 7'h05, 4'h0});
      @(posedge clk); #1;
      exp_q.push_back({5'b00000, 7'h25, 4'h0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      RST = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({busy, op_valid, CEP, done, in_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_abort got busy=%b opv=%b cep=%b done=%b ready=%b required 0",
                     busy, op_valid, CEP, done, in_ready);
         end
      end
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_no_done got busy=%b done=%b required 0 0", busy, done);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rst_words got %0d pending required 0", exp_q.size());
         exp_q.delete();
      end
      run_job(8'd1, 1'b0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0, "after_rst");
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_subtract();
      test_ignored_starts();
      test_preadd();
      test_back_to_back();
      test_reset_mid_job();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish required finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
